// File: rtl/imem_line_reader.sv
// imem_line_reader: instruction-memory line fetch backend.
// Accepts a line request, reads LINE_WORDS consecutive words from a
// single-port synchronous SRAM (1-cycle read latency), assembles them into
// one line and returns it with a single-cycle resp_valid pulse.
// Optional feature macro: IMEM_RANGE_CHECK_EN (adds resp_err and rejects
// requests whose address bits above the SRAM range are nonzero).
//
// Handshake: a request is taken on any rising edge where req_valid=1 and the
// block is in IDLE (processing=0); req_valid is ignored, not queued, in every
// other state. resp_valid is high for exactly one cycle, with resp_data
// (and resp_err when present) valid in that same cycle.
module imem_line_reader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int LINE_WORDS     = 4,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             processing,
    output logic                             resp_valid,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] resp_data,
    output logic                             mem_en,
    output logic [MEM_ADDR_WIDTH-1:0]        mem_addr,
    input  logic [WORD_WIDTH-1:0]            mem_rdata,
`ifdef IMEM_RANGE_CHECK_EN
    output logic                             resp_err,
`endif
    output logic [1:0]                       dbg_state
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int CNT_W    = OFF_BITS + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                            r_state;
    state_t                            w_next_state;
    logic [MEM_ADDR_WIDTH-1:0]         r_base;
    logic [MEM_ADDR_WIDTH-1:0]         r_mem_addr;
    logic [CNT_W-1:0]                  r_issue_cnt;
    logic [CNT_W-1:0]                  r_cap_cnt;
    logic                              r_cap_pend;
    logic [LINE_WORDS*WORD_WIDTH-1:0]  r_resp_data;
    logic                              r_err;

    logic                              w_accept;
    logic                              w_oor;
    logic [MEM_ADDR_WIDTH-1:0]         w_line_base;
    logic [CNT_W-1:0]                  w_issue_inc;
    logic                              w_unused;

    // Line-aligned word address; upper address bits drop out (wrap modulo depth).
    assign w_line_base = {req_addr[MEM_ADDR_WIDTH+1:OFF_BITS+2], {OFF_BITS{1'b0}}};
    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_issue_inc = r_issue_cnt + CNT_W'(1);
    // Byte-offset bits (and upper bits when the range check is off) are not needed.
    assign w_unused    = ^req_addr;

`ifdef IMEM_RANGE_CHECK_EN
    assign w_oor    = |(req_addr >> (MEM_ADDR_WIDTH + 2));
    assign resp_err = (r_state == ST_RESP) && r_err;
`else
    assign w_oor    = 1'b0;
`endif

    assign processing = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign mem_en     = (r_state == ST_READ);
    assign mem_addr   = r_mem_addr;
    assign resp_data  = r_resp_data;
    assign dbg_state  = r_state;

    // Next-state decode for the fetch sequence IDLE -> READ -> DRAIN -> RESP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = w_oor ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                if (r_issue_cnt == LAST_IDX) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register plus address issue, read-data capture and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_mem_addr  <= '0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_cap_pend  <= 1'b0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            // SRAM data arrives one cycle after each enabled read.
            r_cap_pend <= (r_state == ST_READ);

            if (w_accept) begin
                r_issue_cnt <= '0;
                r_cap_cnt   <= '0;
                r_err       <= w_oor;
                if (w_oor) begin
                    r_resp_data <= '0;
                end else begin
                    r_base     <= w_line_base;
                    r_mem_addr <= w_line_base;
                end
            end else if (r_state == ST_READ) begin
                r_issue_cnt <= w_issue_inc;
                // Base is line-aligned, so the offset never carries out of the line.
                if (r_issue_cnt != LAST_IDX) begin
                    r_mem_addr <= r_base + MEM_ADDR_WIDTH'(w_issue_inc);
                end
            end

            if (r_cap_pend) begin
                r_cap_cnt <= r_cap_cnt + CNT_W'(1);
                for (int k = 0; k < LINE_WORDS; k++) begin
                    if (r_cap_cnt == CNT_W'(k)) begin
                        r_resp_data[k*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: doc/imem_line_reader.md
Name: imem_line_reader

Overview:
- Instruction-memory backend that sits directly downstream of the AXI read slave and services its line requests.
- Accepts a line request through the req_valid/req_addr handshake and reads LINE_WORDS consecutive words from a single-port synchronous SRAM, one word per cycle.
- Assembles the words into one line and returns it on resp_data with a single-cycle resp_valid pulse.
- Drives processing while busy so the slave can observe occupancy.

Parameters:
- ADDR_WIDTH, 32, width of req_addr (byte address).
- WORD_WIDTH, 32, width of one SRAM word and of one AXI beat.
- LINE_WORDS, 4, words per line (power of two, ≥2).
- MEM_ADDR_WIDTH, 10, SRAM word-address width; depth = 2^MEM_ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  line request strobe.
- req_addr  in  ADDR_WIDTH  byte address of the request.
- processing  out  1  block busy (state != IDLE).
- resp_valid  out  1  one-cycle pulse: resp_data holds the complete line.
- resp_data  out  LINE_WORDS*WORD_WIDTH  assembled line; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- mem_en  out  1  SRAM read enable.
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_rdata  in  WORD_WIDTH  SRAM read data, valid exactly 1 cycle after mem_en.

Behaviour:
- Reset values, applied at the clk edge where rst=1:
  - state=IDLE
  - processing=0, resp_valid=0, resp_data=0
  - mem_en=0, mem_addr=0
  - all counters=0
- Reset mid-operation aborts the transfer immediately:
  - no resp_valid pulse is produced.
  - any in-flight SRAM data is discarded.
- Address rules:
  - word address = req_addr[MEM_ADDR_WIDTH+1:2].
  - line base = word address with the low log2(LINE_WORDS) bits cleared. Unaligned requests return the full aligned line.
  - Bits of req_addr above MEM_ADDR_WIDTH+1 are ignored; the address wraps modulo the SRAM depth.
- State machine IDLE -> READ -> DRAIN -> RESP -> IDLE:
  - IDLE: when req_valid=1, latch the line base, clear issue_cnt and cap_cnt, and go to READ. req_valid in any other state is ignored, not queued.
  - READ: mem_en=1 and mem_addr=base+issue_cnt each cycle; issue_cnt increments. After the cycle with issue_cnt=LINE_WORDS-1, go to DRAIN.
  - Capture rule: every cycle after a mem_en=1 cycle, mem_rdata is written into resp_data word cap_cnt, then cap_cnt increments.
  - DRAIN: mem_en=0; the last word is captured; go to RESP.
  - RESP: resp_valid=1 for exactly this cycle; go to IDLE.
- Latency: a request accepted at edge T produces mem_en in cycles T+1..T+LINE_WORDS and resp_valid in cycle T+LINE_WORDS+2. Default: 6 cycles from acceptance.
- processing=1 in READ, DRAIN and RESP; 0 in IDLE. A new request is accepted in the cycle after RESP at the earliest.
- resp_data holds the last line until the next request's first capture overwrites word 0. Words are overwritten progressively during the next transfer.
- mem_addr holds its last value when mem_en=0.
- Counter widths are log2(LINE_WORDS)+1 bits; no overflow is possible.
- Base plus offset never carries out of the line because the base is line-aligned.

Optional Feature:
- Macro: IMEM_RANGE_CHECK_EN.
- With the macro defined, an extra output resp_err (1 bit, reset 0) is present.
  - In IDLE, a request with any nonzero req_addr bit above bit MEM_ADDR_WIDTH+1 goes directly to RESP.
  - mem_en stays 0 and resp_data is cleared to 0.
  - resp_valid=1 and resp_err=1 for that one cycle, i.e. response at T+1.
  - In-range requests behave as above with resp_err=0.
- Without the macro: no resp_err port; out-of-range addresses wrap modulo the SRAM depth.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release -> processing=0, resp_valid=0, mem_en=0, resp_data=0.
- Aligned line read: SRAM word i preloaded with 0x1000_0000+i; req_addr=0x40 -> mem_addr 0x10,0x11,0x12,0x13 on consecutive cycles; resp_valid at T+6 for one cycle; resp_data={0x10000013,0x10000012,0x10000011,0x10000010}.
- Unaligned and wrap: req_addr=0x4C -> same line as 0x40. req_addr=0x0000_1000 (depth 1024) -> mem_addr starts at 0x000 (without macro).
- Busy-drop and back-to-back: pulse req_valid at T+2 during READ -> ignored, exactly one resp_valid. A second req_valid in the cycle after RESP is accepted, and resp_data updates to the new line.
- Reset mid-transfer: assert rst in the cycle with issue_cnt=2 -> next cycle state IDLE, mem_en=0, processing=0, no resp_valid pulse afterwards.
- IMEM_RANGE_CHECK_EN defined: req_addr=0x0000_2000 -> mem_en never asserts; resp_valid=1, resp_err=1, resp_data=0 at T+1. A following req_addr=0x40 gives resp_err=0 and correct data.
